control_unit: RTL and testbench

Multi-cycle sequencer for the 16-bit core. Owns the program counter, drives `program_memory` with an instruction address, latches and decodes the returned word, and then steps the ALU, register file and data memory through each instruction. Sits between `program_memory` and the execute datapath, and is the only block that issues register writes or data-memory requests.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/instruction_decoder.sv | 21 ++
 rtl/control_unit.sv | 129 ++++++++++++
 tb/tb_control_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, states and instruction layout for the 16-bit core (CONTROL_UNIT_HALT_EN adds the HALT state)
package cpu_pkg;

  // Bit positions of the instruction fields
  localparam int IR_OPCODE_LSB = 0;
  localparam int IR_OPCODE_MSB = 3;
  localparam int IR_ADDR_LSB   = 4;
  localparam int IR_ADDR_MSB   = 13;
  localparam int IR_REG_LSB    = 14;
  localparam int IR_REG_MSB    = 15;

  // IR contents after reset: a NOP with all other fields zero
  localparam logic [15:0] NOP_WORD = 16'h000F;

  typedef enum logic [3:0] {
    OP_ADD      = 4'd0,
    OP_SUBTRACT = 4'd1,
    OP_AND      = 4'd2,
    OP_OR       = 4'd3,
    OP_XOR      = 4'd4,
    OP_NOT      = 4'd5,
    OP_LOAD     = 4'd6,
    OP_STORE    = 4'd7,
    OP_NOP      = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    CLASS_ALU   = 2'd0,
    CLASS_LOAD  = 2'd1,
    CLASS_STORE = 2'd2,
    CLASS_NOP   = 2'd3
  } op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5
`ifdef CONTROL_UNIT_HALT_EN
    , ST_HALT    = 3'd6
`endif
  } state_e;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [9:0] addr;
    logic [3:0] opcode;
  } instr_t;

endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - maps an opcode to its execution class; unknown opcodes run as NOP
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] op_class
);

  // Pure lookup; everything not explicitly listed falls through to NOP
  always_comb begin
    op_class = CLASS_NOP;
    case (opcode)
      OP_ADD, OP_SUBTRACT, OP_AND,
      OP_OR, OP_XOR, OP_NOT:        op_class = CLASS_ALU;
      OP_LOAD:                      op_class = CLASS_LOAD;
      OP_STORE:                     op_class = CLASS_STORE;
      default:                      op_class = CLASS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer (define CONTROL_UNIT_HALT_EN to stop after the last address)
module control_unit
  import cpu_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32,
  parameter int DATA_ADDR_WIDTH        = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic [3:0]                       alu_op,
  output logic                             alu_en,
  output logic [1:0]                       reg_sel,
  output logic                             reg_we,
  output logic [DATA_ADDR_WIDTH-1:0]       mem_addr,
  output logic                             mem_req,
  output logic                             mem_we,
  input  logic                             mem_ack,
  output logic                             busy,
  output logic                             halted
);

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);

  state_e                           state_q, state_d;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_q, pc_d;
  instr_t                           ir_q, ir_d;
  logic [1:0]                       op_class;
  logic                             advance;

  instruction_decoder u_decoder (
    .opcode   (ir_q.opcode),
    .op_class (op_class)
  );

  // State, PC and IR registers; reset drops every strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= instr_t'(NOP_WORD);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; every instruction ends through the shared advance path
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d.reg_sel = instruction[IR_REG_MSB:IR_REG_LSB];
        ir_d.addr    = instruction[IR_ADDR_MSB:IR_ADDR_LSB];
        ir_d.opcode  = instruction[IR_OPCODE_MSB:IR_OPCODE_LSB];
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        case (op_class)
          CLASS_ALU:               state_d = ST_EXECUTE;
          CLASS_LOAD, CLASS_STORE: state_d = ST_MEM;
          default:                 advance = 1'b1;
        endcase
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_MEM: begin
        // Only LOAD/STORE reach this state, so non-STORE means LOAD
        if (mem_ack) begin
          if (op_class == CLASS_STORE) advance = 1'b1;
          else                         state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        advance = 1'b1;
      end
`ifdef CONTROL_UNIT_HALT_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      pc_d    = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
      state_d = run ? ST_FETCH : ST_IDLE;
`ifdef CONTROL_UNIT_HALT_EN
      if (pc_q == LAST_PC) state_d = ST_HALT;
`endif
    end
  end

  // Outputs come from registers only, never from inputs
  always_comb begin
    instruction_address = pc_q;
    alu_op              = ir_q.opcode;
    reg_sel             = ir_q.reg_sel;
    mem_addr            = ir_q.addr;
    alu_en              = (state_q == ST_EXECUTE);
    reg_we              = (state_q == ST_WRITEBACK);
    mem_req             = (state_q == ST_MEM);
    mem_we              = (state_q == ST_MEM) && (op_class == CLASS_STORE);
`ifdef CONTROL_UNIT_HALT_EN
    halted              = (state_q == ST_HALT);
    busy                = (state_q != ST_IDLE) && (state_q != ST_HALT);
`else
    halted              = 1'b0;
    busy                = (state_q != ST_IDLE);
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [4:0]  instruction_address;
  logic [15:0] instruction;
  logic [3:0]  alu_op;
  logic        alu_en;
  logic [1:0]  reg_sel;
  logic        reg_we;
  logic [9:0]  mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        halted;

  logic [15:0] prog [0:31];
  int          n_checks;
  int          n_errors;
  int          cyc;
  int          alu_cnt;
  int          rwe_cnt;

  control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .run                 (run),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .alu_op              (alu_op),
    .alu_en              (alu_en),
    .reg_sel             (reg_sel),
    .reg_we              (reg_we),
    .mem_addr            (mem_addr),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_ack             (mem_ack),
    .busy                (busy),
    .halted              (halted)
  );

  assign instruction = prog[instruction_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    alu_cnt += int'(alu_en);
    rwe_cnt += int'(reg_we);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    alu_cnt  = 0;
    rwe_cnt  = 0;
    for (int i = 0; i < 32; i++) prog[i] = 16'h000F;
    prog[1]  = 16'h8000;   // ADD, reg_sel=2
    prog[10] = 16'hC256;   // LOAD, reg_sel=3, addr=37
    prog[11] = 16'h4057;   // STORE, reg_sel=1, addr=5
    prog[12] = 16'h000A;   // unknown opcode
    rst_n    = 1'b0;
    run      = 1'b0;
    mem_ack  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(instruction_address), 0);
    check("rst_alu_op", 32'(alu_op), 32'hF);
    check("rst_strobes", 32'({alu_en, reg_we, mem_req, mem_we, busy, halted}), 0);
    check("rst_fields", 32'({reg_sel, mem_addr}), 0);

    // Start: NOP at 0, ADD at 1
    rst_n   = 1'b1;
    run     = 1'b1;
    cyc     = 0;
    alu_cnt = 0;
    rwe_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (cyc == 1) begin
        check("start_addr0", 32'(instruction_address), 0);
        check("start_busy", 32'(busy), 1);
      end
      if (cyc == 5) begin
        check("add_alu_en", 32'({alu_en, reg_we}), 32'b10);
        check("add_alu_op", 32'(alu_op), 0);
      end
      if (cyc == 6) begin
        check("add_reg_we", 32'({alu_en, reg_we}), 32'b01);
        check("add_reg_sel", 32'(reg_sel), 2);
      end
    end
    check("add_alu_cnt", 32'(alu_cnt), 1);
    check("add_rwe_cnt", 32'(rwe_cnt), 1);
    step();
    check("add_next_pc", 32'(instruction_address), 2);

    // LOAD at 10 with three wait cycles
    step_to(23);
    check("ld_fetch_pc", 32'(instruction_address), 10);
    step();
    check("ld_decode_op", 32'(alu_op), 6);
    step();
    rwe_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      check("ld_mem_req", 32'(mem_req), 1);
      check("ld_mem_we", 32'(mem_we), 0);
      check("ld_mem_addr", 32'(mem_addr), 37);
      if (k == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("ld_wb", 32'({mem_req, reg_we}), 32'b01);
    step();
    check("ld_next_pc", 32'(instruction_address), 11);
    check("ld_rwe_cnt", 32'(rwe_cnt), 1);

    // STORE at 11, acked in its first MEM cycle
    rwe_cnt = 0;
    step();
    step();
    check("st_mem", 32'({mem_req, mem_we}), 32'b11);
    check("st_reg_sel", 32'(reg_sel), 1);
    check("st_mem_addr", 32'(mem_addr), 5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_next_pc", 32'(instruction_address), 12);
    check("st_mem_drop", 32'({mem_req, mem_we}), 0);
    check("st_rwe_cnt", 32'(rwe_cnt), 0);

    // Unknown opcode 4'hA at 12 behaves as NOP
    alu_cnt = 0;
    rwe_cnt = 0;
    step();
    check("unk_alu_op", 32'(alu_op), 32'hA);
    check("unk_strobes", 32'({alu_en, reg_we, mem_req}), 0);
    step();
    check("unk_next_pc", 32'(instruction_address), 13);
    check("unk_counts", 32'(alu_cnt + rwe_cnt), 0);

    // Last address (NOP at 31)
    step_to(71);
    check("last_fetch_pc", 32'(instruction_address), 31);
    step();
    step();
`ifdef CONTROL_UNIT_HALT_EN
    check("halt_halted", 32'(halted), 1);
    check("halt_busy", 32'(busy), 0);
    run = 1'b0;
    step();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    check("halt_stays", 32'({halted, busy}), 32'b10);
    check("halt_strobes", 32'({alu_en, reg_we, mem_req}), 0);
`else
    check("wrap_pc", 32'(instruction_address), 0);
    check("wrap_busy", 32'({busy, halted}), 32'b10);
    // Drop run mid-instruction: NOP at 0 completes, then IDLE with PC kept
    run = 1'b0;
    step();
    step();
    check("stop_idle", 32'(busy), 0);
    check("stop_pc", 32'(instruction_address), 1);
    step();
    check("idle_pc_kept", 32'({busy, instruction_address}), 32'(6'd1));
`endif

    // Async reset while a LOAD waits in MEM (NOP at 0, LOAD at 1)
    prog[1] = 16'hC256;
    rst_n   = 1'b0;
    run     = 1'b0;
    step();
    rst_n   = 1'b1;
    run     = 1'b1;
    cyc     = 0;
    rwe_cnt = 0;
    step_to(5);
    check("ar_mem_req", 32'(mem_req), 1);
    check("ar_pc", 32'(instruction_address), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_req_drop", 32'({mem_req, mem_we, busy}), 0);
    check("ar_pc_zero", 32'(instruction_address), 0);
    check("ar_ir_nop", 32'(alu_op), 32'hF);
    step();
    rst_n = 1'b1;
    run   = 1'b0;
    step();
    step();
    check("ar_idle", 32'({busy, halted, instruction_address}), 0);
    check("ar_no_rwe", 32'(rwe_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
